// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
package fifo_pkg;

  // Read-mode encodings for the FWFT parameter.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 32'd0) ? value - 32'd1 : 32'd0;
    while (v > 32'd0) begin
      res = res + 32'd1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Bits needed to hold a word count of 0..2**addr_w inclusive.
  function automatic int unsigned fifo_level_width(input int unsigned addr_w);
    return fifo_clog2((32'd1 << addr_w) + 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module fifo_ram_dp #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rd_rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int unsigned DEPTH = 32'd1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port with output register; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (rd_rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, level and sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_LEVEL   = (32'd1 << ADDRESS_WIDTH) - 32'd16,
  parameter int unsigned AEMPTY_LEVEL  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    d,
  input  logic                     write,
  input  logic                     read,
  input  logic                     clear_flags,
  output logic [DATA_WIDTH-1:0]    q,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned DEPTH     = 32'd1 << ADDRESS_WIDTH;
  localparam int unsigned LEVEL_W   = fifo_level_width(ADDRESS_WIDTH);
  localparam bit          FWFT_MODE = (FWFT == 32'(FIFO_FWFT));

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]       level_q, level_d;
  logic                     empty_q, empty_d;
  logic                     full_q, full_d;
  logic                     afull_q, afull_d;
  logic                     aempty_q, aempty_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0]    byp_q, byp_d;
  logic                     q_from_ram_q, q_from_ram_d;

  logic                     rd_accept;
  logic                     wr_accept;
  logic                     ram_rd_en;
  logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]    ram_rd_data;

  // Accept decisions, pointer/level/flag next state and read-port steering.
  always_comb begin
    rd_accept    = read && !empty_q;
    wr_accept    = write && (!full_q || rd_accept);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    byp_d        = byp_q;
    q_from_ram_d = q_from_ram_q;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = rd_ptr_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
    end

    case ({wr_accept, rd_accept})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase

    empty_d  = (level_d == '0);
    full_d   = (level_d == LEVEL_W'(DEPTH));
    afull_d  = (level_d >= LEVEL_W'(AFULL_LEVEL));
    aempty_d = (level_d <= LEVEL_W'(AEMPTY_LEVEL));

    // New rejection events take priority over a coincident clear.
    overflow_d  = overflow_q && !clear_flags;
    underflow_d = underflow_q && !clear_flags;
    if (write && !wr_accept) begin
      overflow_d = 1'b1;
    end
    if (read && !rd_accept) begin
      underflow_d = 1'b1;
    end

    if (FWFT_MODE) begin
      // Prefetch the word behind the head; words not yet in RAM come from the bypass register.
      ram_rd_addr = rd_ptr_q + ADDRESS_WIDTH'(1);
      if (rd_accept) begin
        if (level_q != LEVEL_W'(1)) begin
          ram_rd_en    = 1'b1;
          q_from_ram_d = 1'b1;
        end else if (wr_accept) begin
          byp_d        = d;
          q_from_ram_d = 1'b0;
        end
      end else if (empty_q && wr_accept) begin
        byp_d        = d;
        q_from_ram_d = 1'b0;
      end
    end else begin
      ram_rd_en = rd_accept;
    end
  end

  // State registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      afull_q      <= 1'b0;
      aempty_q     <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      byp_q        <= '0;
      q_from_ram_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      afull_q      <= afull_d;
      aempty_q     <= aempty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      byp_q        <= byp_d;
      q_from_ram_q <= q_from_ram_d;
    end
  end

  fifo_ram_dp #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rd_rst_i  (reset),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (d),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  assign q            = (FWFT_MODE && !q_from_ram_q) ? byp_q : ram_rd_data;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO share one stimulus stream.
module tb_param_fifo;

  localparam int DEPTH  = 512;
  localparam int AFULL  = DEPTH - 16;
  localparam int AEMPTY = 16;

  logic       clk;
  logic       reset;
  logic [7:0] d;
  logic       write;
  logic       read;
  logic       clear_flags;

  logic [7:0] s_q, f_q;
  logic       s_empty, s_full, s_afull, s_aempty, s_ovf, s_udf;
  logic       f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
  logic [9:0] s_level, f_level;

  param_fifo #(.FWFT(0)) dut_std (
    .clk (clk), .reset (reset), .d (d), .write (write), .read (read),
    .clear_flags (clear_flags), .q (s_q), .empty (s_empty), .full (s_full),
    .almost_full (s_afull), .almost_empty (s_aempty), .level (s_level),
    .overflow (s_ovf), .underflow (s_udf)
  );

  param_fifo #(.FWFT(1)) dut_fwft (
    .clk (clk), .reset (reset), .d (d), .write (write), .read (read),
    .clear_flags (clear_flags), .q (f_q), .empty (f_empty), .full (f_full),
    .almost_full (f_afull), .almost_empty (f_aempty), .level (f_level),
    .overflow (f_ovf), .underflow (f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic       ovf_m, udf_m;
  logic [7:0] std_q_m, fwft_q_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    lvl = mq.size();
    check({tag, ".s.level"},  32'(s_level),  32'(lvl));
    check({tag, ".f.level"},  32'(f_level),  32'(lvl));
    check({tag, ".s.empty"},  32'(s_empty),  32'(lvl == 0));
    check({tag, ".f.empty"},  32'(f_empty),  32'(lvl == 0));
    check({tag, ".s.full"},   32'(s_full),   32'(lvl == DEPTH));
    check({tag, ".f.full"},   32'(f_full),   32'(lvl == DEPTH));
    check({tag, ".s.afull"},  32'(s_afull),  32'(lvl >= AFULL));
    check({tag, ".f.afull"},  32'(f_afull),  32'(lvl >= AFULL));
    check({tag, ".s.aempty"}, 32'(s_aempty), 32'(lvl <= AEMPTY));
    check({tag, ".f.aempty"}, 32'(f_aempty), 32'(lvl <= AEMPTY));
    check({tag, ".s.ovf"},    32'(s_ovf),    32'(ovf_m));
    check({tag, ".f.ovf"},    32'(f_ovf),    32'(ovf_m));
    check({tag, ".s.udf"},    32'(s_udf),    32'(udf_m));
    check({tag, ".f.udf"},    32'(f_udf),    32'(udf_m));
    check({tag, ".s.q"},      32'(s_q),      32'(std_q_m));
    check({tag, ".f.q"},      32'(f_q),      32'(fwft_q_m));
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] data,
                      input logic clr, input logic rst);
    logic rd_acc, wr_acc;
    write = w; read = r; d = data; clear_flags = clr; reset = rst;
    if (rst) begin
      mq.delete(); sb.delete();
      ovf_m = 1'b0; udf_m = 1'b0; std_q_m = 8'h00; fwft_q_m = 8'h00;
    end else begin
      rd_acc = r && (mq.size() != 0);
      wr_acc = w && ((mq.size() < DEPTH) || rd_acc);
      ovf_m  = (ovf_m && !clr) || (w && !wr_acc);
      udf_m  = (udf_m && !clr) || (r && !rd_acc);
      if (rd_acc) sb.push_back(mq.pop_front());
      if (wr_acc) mq.push_back(data);
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) std_q_m = sb.pop_front();
    if (mq.size() != 0) fwft_q_m = mq[0];
    check_all(tag);
  endtask

  initial begin
    int pw;
    int pr;
    reset = 1'b1; write = 1'b0; read = 1'b0; d = 8'h00; clear_flags = 1'b0;
    mq.delete(); sb.delete();
    ovf_m = 1'b0; udf_m = 1'b0; std_q_m = 8'h00; fwft_q_m = 8'h00;

    // Reset state.
    step("rst0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step("rst1", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);

    // Fill to full with a wrapping byte pattern, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step("ovf", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Write+read on full, then drain so 0x77 emerges last after the pointers wrap.
    step("full_wr_rd", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("rd_empty", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("clr_udf", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Single word write then read.
    step("wr_a5", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    step("rd_a5", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("idle_a5", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Write+read on empty, clear, then clear coinciding with a new underflow.
    step("wr_rd_empty", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    step("clr_udf2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("rd_11", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("clr_vs_udf", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step("clr_udf3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Burst to level 200, reset mid-burst with write and read active.
    for (int i = 0; i < 200; i++) step("burst", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    step("rst_mid", 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    step("rd_after_rst", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step("clr_udf4", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 35;
      pr = (ph % 2 == 0) ? 35 : 80;
      for (int i = 0; i < 700; i++) begin
        step("rand",
             $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr,
             8'($urandom),
             $urandom_range(0, 99) < 3,
             1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
